// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8N1, or 8E1 when UART_RX_PARITY_EN is defined
// Pin is double-synchronised; every bit is sampled at its mid-point.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic       uart_rx_complete,
  output logic [7:0] uart_rx_data,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Counters count down to zero, so loads are one less than the interval.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif

  logic          sync1_q, rxs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          pmis_q, pmis_d;
  logic          perr_q, perr_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= UART_RXD;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmis_d  = pmis_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          // A start bit that is high again at mid-point is a glitch.
          if (!rxs_q) begin
            cnt_d   = BIT_M1;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = BIT_M1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          pmis_d  = (rxs_q != (^shift_q));
          cnt_d   = BIT_M1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (pmis_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shift_q;
              done_d = 1'b1;
            end
`else
            data_d = shift_q;
            done_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pmis_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pmis_q <= pmis_d;
      perr_q <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign uart_rx_complete = done_q;
  assign uart_rx_data     = data_q;
  assign framing_error    = ferr_q;

endmodule
